// File: rtl/alu_share_ctrl_pkg.sv
// rtl/alu_share_ctrl_pkg.sv - shared widths, ALU opcodes and controller state encodings
package alu_share_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int OPRN_W = 6;

    localparam logic [OPRN_W-1:0] OP_ADD = 6'd1;
    localparam logic [OPRN_W-1:0] OP_SUB = 6'd2;
    localparam logic [OPRN_W-1:0] OP_MUL = 6'd3;
    localparam logic [OPRN_W-1:0] OP_SRL = 6'd4;
    localparam logic [OPRN_W-1:0] OP_SLL = 6'd5;
    localparam logic [OPRN_W-1:0] OP_AND = 6'd6;
    localparam logic [OPRN_W-1:0] OP_OR  = 6'd7;
    localparam logic [OPRN_W-1:0] OP_NOR = 6'd8;
    localparam logic [OPRN_W-1:0] OP_SLT = 6'd9;

    typedef enum logic [1:0] {
        ALU_CTRL_IDLE = 2'b00,
        ALU_CTRL_EXEC = 2'b01,
        ALU_CTRL_RESP = 2'b10
    } ctrl_state_t;

    // Opcode 0 is reserved; anything above the highest implemented opcode is rejected.
    function automatic logic oprn_illegal(input logic [OPRN_W-1:0] oprn, input int unsigned max_oprn);
        return (oprn == '0) || (32'(oprn) > max_oprn);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; caller owns the last_grant history bit
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       any
);

    // On contention the requester that did not win last time gets the grant.
    assign grant[0] = req[0] & (~req[1] | last_grant);
    assign grant[1] = req[1] & (~req[0] | ~last_grant);
    assign any      = |req;

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one combinational ALU between two valid/ready requesters
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 2,
    parameter int unsigned MAX_OPRN    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [OPRN_W-1:0] req0_oprn,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_zero,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [OPRN_W-1:0] req1_oprn,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_zero,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OPRN_W-1:0] alu_oprn,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              busy
);

    ctrl_state_t       state, state_nxt;
    logic [3:0]        cnt;
    logic              owner, err, last_grant;
    logic [1:0]        grant;
    logic              grant_any;
    logic              idle, accept, owner_rsp_ready;
    logic [OPRN_W-1:0] sel_oprn;
    logic [DATA_W-1:0] cap_data;
    logic              cap_zero;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (grant_any)
    );

    assign idle            = (state == ALU_CTRL_IDLE);
    assign req0_ready      = idle & grant[0];
    assign req1_ready      = idle & grant[1];
    assign accept          = idle & grant_any;
    assign busy            = ~idle;
    assign rsp0_valid      = (state == ALU_CTRL_RESP) & ~owner;
    assign rsp1_valid      = (state == ALU_CTRL_RESP) & owner;
    assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
    assign sel_oprn        = grant[1] ? req1_oprn : req0_oprn;
    // Illegal opcodes report a clean zero result instead of whatever the ALU produced.
    assign cap_data        = err ? '0 : alu_out;
    assign cap_zero        = err | alu_zero;

    always_comb begin
        state_nxt = state;
        case (state)
            ALU_CTRL_IDLE: if (accept) state_nxt = ALU_CTRL_EXEC;
            ALU_CTRL_EXEC: if (cnt == '0) state_nxt = ALU_CTRL_RESP;
            ALU_CTRL_RESP: if (owner_rsp_ready) state_nxt = ALU_CTRL_IDLE;
            default:       state_nxt = ALU_CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ALU_CTRL_IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            err        <= 1'b0;
            last_grant <= 1'b1;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_oprn   <= '0;
            rsp0_data  <= '0;
            rsp0_zero  <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_data  <= '0;
            rsp1_zero  <= 1'b0;
            rsp1_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ALU_CTRL_IDLE: begin
                    if (accept) begin
                        alu_op1    <= grant[1] ? req1_op1 : req0_op1;
                        alu_op2    <= grant[1] ? req1_op2 : req0_op2;
                        alu_oprn   <= sel_oprn;
                        owner      <= grant[1];
                        err        <= oprn_illegal(sel_oprn, MAX_OPRN);
                        last_grant <= grant[1];
                        cnt        <= 4'(EXEC_CYCLES - 1);
                    end
                end
                ALU_CTRL_EXEC: begin
                    if (cnt == '0) begin
                        if (owner) begin
                            rsp1_data <= cap_data;
                            rsp1_zero <= cap_zero;
                            rsp1_err  <= err;
                        end else begin
                            rsp0_data <= cap_data;
                            rsp0_zero <= cap_zero;
                            rsp0_err  <= err;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed table-driven bench for alu_share_ctrl with a behavioural ALU
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    typedef struct {
        logic        p;
        logic [5:0]  oprn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ed;
        logic        ez;
        logic        ee;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0_valid[3], req0_ready[3], rsp0_valid[3], rsp0_ready[3], rsp0_zero[3], rsp0_err[3];
    logic        req1_valid[3], req1_ready[3], rsp1_valid[3], rsp1_ready[3], rsp1_zero[3], rsp1_err[3];
    logic [31:0] req0_op1[3], req0_op2[3], rsp0_data[3];
    logic [31:0] req1_op1[3], req1_op2[3], rsp1_data[3];
    logic [5:0]  req0_oprn[3], req1_oprn[3], alu_oprn[3];
    logic [31:0] alu_op1[3], alu_op2[3];
    logic        busy[3];

    int total = 0;
    int bad = 0;

    function automatic logic [31:0] alu_f(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'hDEADBEEF;
        case (o)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_MUL: r = a * b;
            OP_SRL: r = a >> b[4:0];
            OP_SLL: r = a << b[4:0];
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_SLT: r = {31'b0, $signed(a) < $signed(b)};
            default: r = 32'hDEADBEEF;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] a_out;
        logic        a_zero;
        assign a_out  = alu_f(alu_oprn[g], alu_op1[g], alu_op2[g]);
        assign a_zero = (a_out == 32'd0);

        alu_share_ctrl #(.EXEC_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 15)), .MAX_OPRN(9)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(req0_valid[g]), .req0_ready(req0_ready[g]), .req0_op1(req0_op1[g]),
            .req0_op2(req0_op2[g]), .req0_oprn(req0_oprn[g]),
            .rsp0_valid(rsp0_valid[g]), .rsp0_ready(rsp0_ready[g]), .rsp0_data(rsp0_data[g]),
            .rsp0_zero(rsp0_zero[g]), .rsp0_err(rsp0_err[g]),
            .req1_valid(req1_valid[g]), .req1_ready(req1_ready[g]), .req1_op1(req1_op1[g]),
            .req1_op2(req1_op2[g]), .req1_oprn(req1_oprn[g]),
            .rsp1_valid(rsp1_valid[g]), .rsp1_ready(rsp1_ready[g]), .rsp1_data(rsp1_data[g]),
            .rsp1_zero(rsp1_zero[g]), .rsp1_err(rsp1_err[g]),
            .alu_op1(alu_op1[g]), .alu_op2(alu_op2[g]), .alu_oprn(alu_oprn[g]),
            .alu_out(a_out), .alu_zero(a_zero), .busy(busy[g])
        );
    end

    function automatic int ec_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    function automatic logic rv(input int d, input logic p);
        return p ? rsp1_valid[d] : rsp0_valid[d];
    endfunction

    function automatic logic [31:0] rd(input int d, input logic p);
        return p ? rsp1_data[d] : rsp0_data[d];
    endfunction

    function automatic logic rz(input int d, input logic p);
        return p ? rsp1_zero[d] : rsp0_zero[d];
    endfunction

    function automatic logic re(input int d, input logic p);
        return p ? rsp1_err[d] : rsp0_err[d];
    endfunction

    function automatic logic rr(input int d, input logic p);
        return p ? req1_ready[d] : req0_ready[d];
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic set_req(input int d, input logic p, input logic v, input logic [5:0] o,
                           input logic [31:0] a, input logic [31:0] b);
        if (p) begin
            req1_valid[d] = v; req1_oprn[d] = o; req1_op1[d] = a; req1_op2[d] = b;
        end else begin
            req0_valid[d] = v; req0_oprn[d] = o; req0_op1[d] = a; req0_op2[d] = b;
        end
    endtask

    // Called at the negedge right after the handshake edge; returns at the negedge where the response shows.
    task automatic wait_rsp(input int d, input logic p, input logic [5:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ed, input logic ez, input logic ee);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("alu_op1_hold", alu_op1[d], a);
            check("alu_op2_hold", alu_op2[d], b);
            check("alu_oprn_hold", {26'b0, alu_oprn[d]}, {26'b0, o});
        end while (!rv(d, p) && n < 40);
        check("rsp_latency", n, ec_of(d));
        check("rsp_data", rd(d, p), ed);
        check("rsp_zero", rz(d, p), ez);
        check("rsp_err", re(d, p), ee);
    endtask

    task automatic run_op(input int d, input logic p, input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ed, input logic ez, input logic ee);
        set_req(d, p, 1'b1, o, a, b);
        #1;
        check("req_ready_same_cycle", rr(d, p), 1'b1);
        @(negedge clk);
        set_req(d, p, 1'b0, o, a, b);
        wait_rsp(d, p, o, a, b, ed, ez, ee);
        @(negedge clk);
        check("rsp_valid_consumed", rv(d, p), 1'b0);
        check("busy_after_consume", busy[d], 1'b0);
    endtask

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            set_req(d, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
            set_req(d, 1'b1, 1'b0, 6'd0, 32'd0, 32'd0);
            rsp0_ready[d] = 1'b1;
            rsp1_ready[d] = 1'b1;
        end
        vecs[0]  = '{1'b0, OP_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, OP_SRL, 32'h80, 32'd4, 32'h8, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, OP_SLL, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, OP_NOR, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 6'h0A, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 6'h00, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, OP_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[11] = '{1'b0, OP_SLT, 32'd9, 32'd2, 32'd0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy[0], 1'b0);
        check("reset_alu_op1", alu_op1[0], 32'd0);
        check("reset_alu_oprn", {26'b0, alu_oprn[0]}, 32'd0);
        check("reset_rsp0_valid", rsp0_valid[0], 1'b0);
        check("reset_rsp1_data", rsp1_data[0], 32'd0);
        check("reset_rsp0_zero", rsp0_zero[0], 1'b0);
        check("reset_req0_ready_idle", req0_ready[0], 1'b0);

        for (int i = 0; i < 12; i++)
            run_op(0, vecs[i].p, vecs[i].oprn, vecs[i].a, vecs[i].b, vecs[i].ed, vecs[i].ez, vecs[i].ee);

        // Contention: last grant was port 0 (vector 11), so port 1 must win first here.
        set_req(0, 1'b0, 1'b1, OP_SUB, 32'd7, 32'd7);
        set_req(0, 1'b1, 1'b1, OP_OR, 32'hF0, 32'h0F);
        #1;
        check("both_req1_wins", req1_ready[0], 1'b1);
        check("both_req0_waits", req0_ready[0], 1'b0);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, OP_OR, 32'hF0, 32'h0F);
        check("exec_no_ready", req0_ready[0], 1'b0);
        wait_rsp(0, 1'b1, OP_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        @(negedge clk);
        check("req0_ready_next", req0_ready[0], 1'b1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, OP_SUB, 32'd7, 32'd7);
        wait_rsp(0, 1'b0, OP_SUB, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("nonowner_rsp1_data_kept", rsp1_data[0], 32'hFF);
        set_req(0, 1'b0, 1'b1, OP_ADD, 32'd0, 32'd0);
        set_req(0, 1'b1, 1'b1, OP_ADD, 32'd0, 32'd0);
        #1;
        check("alt_req1_wins", req1_ready[0], 1'b1);
        check("alt_req0_waits", req0_ready[0], 1'b0);
        set_req(0, 1'b0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(0, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge clk);
        check("withdraw_idle", busy[0], 1'b0);

        // Backpressure on port 1 stalls port 0 too.
        rsp1_ready[0] = 1'b0;
        set_req(0, 1'b1, 1'b1, OP_SLT, 32'd2, 32'd9);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, OP_SLT, 32'd2, 32'd9);
        wait_rsp(0, 1'b1, OP_SLT, 32'd2, 32'd9, 32'd1, 1'b0, 1'b0);
        set_req(0, 1'b0, 1'b1, OP_ADD, 32'd4, 32'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp1_valid", rsp1_valid[0], 1'b1);
            check("bp_rsp1_data", rsp1_data[0], 32'd1);
            check("bp_req0_blocked", req0_ready[0], 1'b0);
        end
        rsp1_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_released_rsp1", rsp1_valid[0], 1'b0);
        check("bp_req0_ready", req0_ready[0], 1'b1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, OP_ADD, 32'd4, 32'd5);
        wait_rsp(0, 1'b0, OP_ADD, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0);
        @(negedge clk);

        // Reset while port 1's multiply is in flight.
        set_req(0, 1'b1, 1'b1, OP_MUL, 32'd6, 32'd7);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, OP_MUL, 32'd6, 32'd7);
        check("mid_busy", busy[0], 1'b1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy[0], 1'b0);
        check("arst_alu_op1", alu_op1[0], 32'd0);
        check("arst_alu_op2", alu_op2[0], 32'd0);
        check("arst_alu_oprn", {26'b0, alu_oprn[0]}, 32'd0);
        check("arst_rsp0_data", rsp0_data[0], 32'd0);
        check("arst_rsp1_data", rsp1_data[0], 32'd0);
        check("arst_rsp1_valid", rsp1_valid[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp1", rsp1_valid[0], 1'b0);
        end
        set_req(0, 1'b0, 1'b1, OP_ADD, 32'd1, 32'd2);
        set_req(0, 1'b1, 1'b1, OP_ADD, 32'd1, 32'd2);
        #1;
        check("post_rst_req0_first", req0_ready[0], 1'b1);
        set_req(0, 1'b1, 1'b0, OP_ADD, 32'd1, 32'd2);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, OP_ADD, 32'd1, 32'd2);
        wait_rsp(0, 1'b0, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        @(negedge clk);

        run_op(1, 1'b0, OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        run_op(2, 1'b1, OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
